// File: rtl/prbs2_pkg.sv
// Shared constants and types for the 2-bit-per-step XNOR PRBS blocks.
// Generator and checker both use these taps and the state encoding.
package prbs2_pkg;

   localparam int LFSR_W = 8;
   localparam int SYM_W  = 2;

   localparam logic [LFSR_W-1:0] TAP_B1 = 8'b1011_1000;
   localparam logic [LFSR_W-1:0] TAP_B2 = 8'b0101_1100;

   localparam logic [LFSR_W-1:0] LOCKUP_PATTERN = 8'hFF;

   typedef enum logic [1:0] {
      SEED,
      VERIFY,
      LOCKED
   } state_e;

endpackage

// File: rtl/prbs2_step.sv
// One generator step: next 2-bit symbol and next LFSR state.
// Purely combinational so generator and checker can share it.
module prbs2_step
   import prbs2_pkg::*;
(
   input  logic [LFSR_W-1:0] st_i,
   output logic [SYM_W-1:0]  sym_o,
   output logic [LFSR_W-1:0] st_o
);

   logic p1;
   logic p2;

   // XNOR feedback of both tap sets, then shift both bits in
   always_comb begin
      p1    = ~(^(st_i & TAP_B1));
      p2    = ~(^(st_i & TAP_B2));
      sym_o = {p1, p2};
      st_o  = {st_i[LFSR_W-SYM_W-1:0], p1, p2};
   end

endmodule

// File: rtl/prbs2_checker.sv
// Self-synchronising receive checker for the 2-bit XNOR PRBS stream.
// Seeds from the line, verifies, locks, then counts mismatches.
module prbs2_checker
   import prbs2_pkg::*;
#(
   parameter int LOCK_SYMS = 8,
   parameter int LOSS_ERRS = 4,
   parameter int LOSS_WIN  = 32,
   parameter int CNT_W     = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [1:0]       sym_i,
   input  logic             clear_i,
   output logic             locked_o,
   output logic             err_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   localparam logic [7:0] LOCK_C = 8'(LOCK_SYMS);
   localparam logic [7:0] ERRS_C = 8'(LOSS_ERRS);
   localparam logic [7:0] WIN_C  = 8'(LOSS_WIN);

   state_e             state_q, state_d;
   logic [LFSR_W-1:0]  st_q, st_d;
   logic [1:0]         fill_q, fill_d;
   logic [7:0]         match_q, match_d;
   logic [7:0]         wcnt_q, wcnt_d;
   logic [7:0]         werr_q, werr_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [SYM_W-1:0]   pred;
   logic [LFSR_W-1:0]  st_pred;
   logic               mism;
   logic               lockup;

   prbs2_step u_step (
      .st_i  (st_q),
      .sym_o (pred),
      .st_o  (st_pred)
   );

   assign mism   = (sym_i != pred);
   assign lockup = (st_q == LOCKUP_PATTERN);

   // Next-state: seed fill, verify run length, locked error tracking
   always_comb begin
      state_d = state_q;
      st_d    = st_q;
      fill_d  = fill_q;
      match_d = match_q;
      wcnt_d  = wcnt_q;
      werr_d  = werr_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      if (en_i) begin
         unique case (state_q)
            SEED: begin
               st_d   = {st_q[LFSR_W-SYM_W-1:0], sym_i};
               fill_d = fill_q + 2'd1;
               if (fill_q == 2'd3) begin
                  state_d = VERIFY;
                  match_d = 8'd0;
               end
            end
            VERIFY: begin
               st_d = {st_q[LFSR_W-SYM_W-1:0], sym_i};
               if (!mism && !lockup) begin
                  match_d = match_q + 8'd1;
                  if (match_d == LOCK_C) begin
                     state_d = LOCKED;
                     wcnt_d  = 8'd0;
                     werr_d  = 8'd0;
                  end
               end else begin
                  match_d = 8'd0;
               end
            end
            LOCKED: begin
               st_d  = st_pred;
               err_d = mism;
               if (mism && (cnt_q != {CNT_W{1'b1}})) begin
                  cnt_d = cnt_q + 1'b1;
               end
               wcnt_d = wcnt_q + 8'd1;
               if (wcnt_d == WIN_C) begin
                  wcnt_d = 8'd0;
                  werr_d = {7'd0, mism};
               end else begin
                  werr_d = werr_q + {7'd0, mism};
               end
               if (werr_d == ERRS_C) begin
                  state_d = SEED;
                  fill_d  = 2'd0;
               end
            end
            default: begin
               state_d = SEED;
               fill_d  = 2'd0;
            end
         endcase
      end
      if (clear_i) begin
         cnt_d = '0;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= SEED;
         st_q    <= '0;
         fill_q  <= 2'd0;
         match_q <= 8'd0;
         wcnt_q  <= 8'd0;
         werr_q  <= 8'd0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         fill_q  <= fill_d;
         match_q <= match_d;
         wcnt_q  <= wcnt_d;
         werr_q  <= werr_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign locked_o  = (state_q == LOCKED);
   assign err_o     = err_q;
   assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_prbs2_checker.sv
// Bench for prbs2_checker: vector table for first lock plus
// scoreboarded scenarios for errors, loss, saturation and reset.
module tb_prbs2_checker;

   localparam int LOCK_SYMS = 8;
   localparam int LOSS_ERRS = 4;
   localparam int LOSS_WIN  = 32;
   localparam int CNT_W     = 4;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b0;
   logic             en_i = 1'b0;
   logic [1:0]       sym_i = 2'b00;
   logic             clear_i = 1'b0;
   logic             locked_o;
   logic             err_o;
   logic [CNT_W-1:0] err_cnt_o;

   prbs2_checker #(
      .LOCK_SYMS (LOCK_SYMS),
      .LOSS_ERRS (LOSS_ERRS),
      .LOSS_WIN  (LOSS_WIN),
      .CNT_W     (CNT_W)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (en_i),
      .sym_i     (sym_i),
      .clear_i   (clear_i),
      .locked_o  (locked_o),
      .err_o     (err_o),
      .err_cnt_o (err_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit locked;
      bit err;
      int cnt;
   } exp_t;

   typedef struct {
      bit       en;
      bit [1:0] sym;
      bit       clr;
      bit       exp_locked;
   } vec_t;

   exp_t     sb[$];
   int       n_cmp = 0;
   int       n_bad = 0;

   // transmitter model
   bit [7:0] g_st;

   // checker reference model
   int       m_state;
   bit [7:0] m_st;
   int       m_fill, m_match, m_wc, m_we, m_cnt;
   bit       m_err;

   function automatic bit [1:0] pred(input bit [7:0] s);
      bit a, b;
      a = ~(s[7] ^ s[5] ^ s[4] ^ s[3]);
      b = ~(s[6] ^ s[4] ^ s[3] ^ s[2]);
      return {a, b};
   endfunction

   function automatic bit [1:0] gen_next();
      bit [1:0] s;
      s    = pred(g_st);
      g_st = {g_st[5:0], s};
      return s;
   endfunction

   task automatic model_reset();
      m_state = 0;
      m_st    = 8'h00;
      m_fill  = 0;
      m_match = 0;
      m_wc    = 0;
      m_we    = 0;
      m_cnt   = 0;
      m_err   = 0;
   endtask

   task automatic model(input bit en, input bit [1:0] sym, input bit clr);
      bit [1:0] p;
      bit       mm;
      m_err = 0;
      if (en) begin
         p  = pred(m_st);
         mm = (sym != p);
         if (m_state == 0) begin
            m_st   = {m_st[5:0], sym};
            m_fill = m_fill + 1;
            if (m_fill == 4) begin
               m_state = 1;
               m_match = 0;
            end
         end else if (m_state == 1) begin
            if (!mm && m_st != 8'hFF) begin
               m_match = m_match + 1;
               if (m_match == LOCK_SYMS) begin
                  m_state = 2;
                  m_wc    = 0;
                  m_we    = 0;
               end
            end else begin
               m_match = 0;
            end
            m_st = {m_st[5:0], sym};
         end else begin
            m_st = {m_st[5:0], p};
            if (mm) begin
               m_err = 1;
               if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            end
            m_wc = m_wc + 1;
            if (m_wc == LOSS_WIN) begin
               m_wc = 0;
               m_we = mm ? 1 : 0;
            end else begin
               m_we = m_we + (mm ? 1 : 0);
            end
            if (m_we == LOSS_ERRS) begin
               m_state = 0;
               m_fill  = 0;
            end
         end
      end
      if (clr) m_cnt = 0;
   endtask

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic sb_check();
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_empty", 1, 0);
         return;
      end
      e = sb.pop_front();
      chk("sb_locked", int'(locked_o), int'(e.locked));
      chk("sb_err", int'(err_o), int'(e.err));
      chk("sb_cnt", int'(err_cnt_o), e.cnt);
   endtask

   task automatic step(input bit en, input bit [1:0] sym, input bit clr);
      exp_t e;
      @(negedge clk_i);
      en_i    = en;
      sym_i   = sym;
      clear_i = clr;
      model(en, sym, clr);
      e.locked = (m_state == 2);
      e.err    = m_err;
      e.cnt    = m_cnt;
      sb.push_back(e);
      @(posedge clk_i);
      #1;
      sb_check();
   endtask

   task automatic clean(input bit clr = 0);
      bit [1:0] s;
      s = gen_next();
      step(1, s, clr);
   endtask

   task automatic corrupt(input bit clr = 0);
      bit [1:0] s;
      s = gen_next();
      step(1, s ^ 2'b01, clr);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      #2;
      rst_i   = 1'b0;
      en_i    = 1'b0;
      clear_i = 1'b0;
      #1;
      chk("rst_locked", int'(locked_o), 0);
      chk("rst_err", int'(err_o), 0);
      chk("rst_cnt", int'(err_cnt_o), 0);
      model_reset();
      g_st = 8'h00;
      sb.delete();
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   task automatic wait_lock(output int n);
      n = 0;
      while (!locked_o && n < 200) begin
         clean();
         n++;
      end
      if (!locked_o) chk("lock_timeout", 0, 1);
   endtask

   task automatic align_window();
      while (m_wc > 20) clean();
   endtask

   vec_t tbl[12];
   int   n;
   int   seen;

   initial begin
      model_reset();
      g_st = 8'h00;
      #23;
      chk("por_locked", int'(locked_o), 0);
      chk("por_err", int'(err_o), 0);
      chk("por_cnt", int'(err_cnt_o), 0);
      @(negedge clk_i);
      rst_i = 1'b1;

      // first lock from a clean stream, seed 0
      for (int i = 0; i < 12; i++) begin
         tbl[i].en         = 1'b1;
         tbl[i].sym        = gen_next();
         tbl[i].clr        = 1'b0;
         tbl[i].exp_locked = (i == 11);
      end
      g_st = 8'h00;
      for (int i = 0; i < 12; i++) begin
         void'(gen_next());
         step(tbl[i].en, tbl[i].sym, tbl[i].clr);
         chk($sformatf("tbl_locked_%0d", i), int'(locked_o),
             int'(tbl[i].exp_locked));
      end

      repeat (1000) clean();
      chk("clean_cnt", int'(err_cnt_o), 0);
      chk("clean_locked", int'(locked_o), 1);

      // single symbol flip
      corrupt();
      chk("flip_err", int'(err_o), 1);
      chk("flip_cnt", int'(err_cnt_o), 1);
      clean();
      chk("flip_pulse_end", int'(err_o), 0);
      repeat (40) clean();
      chk("flip_after_cnt", int'(err_cnt_o), 1);
      chk("flip_locked", int'(locked_o), 1);

      // four errors in a window drop lock, then relock
      clean(1);
      chk("clear_cnt", int'(err_cnt_o), 0);
      align_window();
      repeat (3) corrupt();
      chk("loss_pre_locked", int'(locked_o), 1);
      corrupt();
      chk("loss_locked", int'(locked_o), 0);
      chk("loss_cnt", int'(err_cnt_o), 4);
      chk("loss_err", int'(err_o), 1);
      wait_lock(n);
      chk("relock_syms", n, 12);

      // saturation: errors spaced so lock holds
      repeat (17) begin
         corrupt();
         repeat (10) clean();
      end
      chk("sat_cnt", int'(err_cnt_o), CNT_MAX);
      chk("sat_locked", int'(locked_o), 1);
      corrupt();
      chk("sat_hold", int'(err_cnt_o), CNT_MAX);

      // lose lock, enter VERIFY, reset asynchronously
      align_window();
      repeat (4) corrupt();
      chk("loss2_locked", int'(locked_o), 0);
      chk("loss2_cnt", int'(err_cnt_o), CNT_MAX);
      repeat (6) clean();
      do_reset();

      // clear coincident with mismatch
      wait_lock(n);
      chk("lock2_syms", n, 12);
      corrupt();
      chk("pre_clr_cnt", int'(err_cnt_o), 1);
      corrupt(1);
      chk("clr_mm_cnt", int'(err_cnt_o), 0);
      chk("clr_mm_err", int'(err_o), 1);
      chk("clr_mm_locked", int'(locked_o), 1);

      // sparse enables
      do_reset();
      n = 0;
      while (!locked_o && n < 100) begin
         clean();
         n++;
         step(0, 2'($urandom_range(0, 3)), 0);
         step(0, 2'($urandom_range(0, 3)), 0);
      end
      chk("sparse_syms", n, 12);

      // stuck-high line must never lock
      do_reset();
      seen = 0;
      repeat (80) begin
         step(1, 2'b11, 0);
         if (locked_o) seen = 1;
      end
      chk("lockup_never", seen, 0);
      chk("lockup_cnt", int'(err_cnt_o), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
